// File: rtl/fft16_radix4_butterfly_pkg.sv
// rtl/fft16_radix4_butterfly_pkg.sv - shared widths, slot pack/unpack helpers and Q1.8 twiddle table
// Contents: DW/TW widths, complex sample and twiddle types, get_slot/put_slot
// for the 4-slot calc bus, twiddle_idx (n*k) and twiddle (W16^p lookup).
package fft_pkg;

  localparam int DW     = 17;            // signed Q8.8 component
  localparam int TW     = 10;            // signed Q1.8 coefficient
  localparam int SLOT_W = 2 * DW;        // one complex sample
  localparam int BUS_W  = 4 * SLOT_W;    // four complex samples

  // Real part sits in the upper half of a slot, matching the bus packing.
  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic [TW-1:0] re;
    logic [TW-1:0] im;
  } twiddle_t;

  function automatic cplx_t get_slot(input logic [BUS_W-1:0] bus, input int m);
    return bus[SLOT_W*m +: SLOT_W];
  endfunction

  function automatic logic [BUS_W-1:0] put_slot(input logic [BUS_W-1:0] bus,
                                                input int m, input cplx_t s);
    logic [BUS_W-1:0] r;
    r = bus;
    r[SLOT_W*m +: SLOT_W] = s;
    return r;
  endfunction

  // Twiddle exponent for pass n, slot k; n,k <= 3 so the product fits in 4 bits.
  function automatic logic [3:0] twiddle_idx(input logic [1:0] n, input logic [1:0] k);
    return 4'(n) * 4'(k);
  endfunction

  // W16^p = cos(2*pi*p/16) - j*sin(2*pi*p/16). p = 0 and p = 4 are handled
  // exactly by the datapath, so their entries are never multiplied.
  function automatic twiddle_t twiddle(input logic [3:0] p);
    twiddle_t t;
    case (p)
      4'd1:    begin t.re = 10'sd237;  t.im = -10'sd98;  end
      4'd2:    begin t.re = 10'sd181;  t.im = -10'sd181; end
      4'd3:    begin t.re = 10'sd98;   t.im = -10'sd237; end
      4'd6:    begin t.re = -10'sd181; t.im = -10'sd181; end
      4'd9:    begin t.re = -10'sd237; t.im = 10'sd98;   end
      default: begin t.re = '0;        t.im = '0;        end
    endcase
    return t;
  endfunction

endpackage

// File: rtl/fft16_radix4_butterfly_if.sv
// rtl/fft16_radix4_butterfly_if.sv - calc bus between FFT controller and butterfly
// Signals: calc_in (4 packed complex inputs), rotation ({stage, pass}),
// calc_out (4 packed complex results). master drives inputs, slave drives calc_out.
interface fft16_radix4_butterfly_if;
  import fft_pkg::*;

  logic [BUS_W-1:0] calc_in;
  logic [2:0]       rotation;
  logic [BUS_W-1:0] calc_out;

  modport master (output calc_in, output rotation, input calc_out);
  modport slave  (input calc_in, input rotation, output calc_out);

endinterface

// File: rtl/fft16_radix4_butterfly_cmplx_mult_q8.sv
// rtl/fft16_radix4_butterfly_cmplx_mult_q8.sv - Q8.8 x Q1.8 complex multiply, truncated back to Q8.8
// Ports: a (complex Q8.8 in), w (complex Q1.8 twiddle), p (complex Q8.8 product).
module cmplx_mult_q8
  import fft_pkg::*;
(
  input  cplx_t    a,
  input  twiddle_t w,
  output cplx_t    p
);

  localparam int PW = DW + TW + 1;   // product width plus one bit for the sum

  logic signed [DW-1:0] ar, ai;
  logic signed [TW-1:0] wr, wi;
  logic signed [PW-1:0] ar_x, ai_x, wr_x, wi_x;
  logic signed [PW-1:0] re_full, im_full;

  assign ar = a.re;
  assign ai = a.im;
  assign wr = w.re;
  assign wi = w.im;

  assign ar_x = PW'(ar);
  assign ai_x = PW'(ai);
  assign wr_x = PW'(wr);
  assign wi_x = PW'(wi);

  assign re_full = ar_x * wr_x - ai_x * wi_x;
  assign im_full = ar_x * wi_x + ai_x * wr_x;

  // Single arithmetic shift at the end (floor), then wrap to DW bits.
  assign p.re = DW'(re_full >>> 8);
  assign p.im = DW'(im_full >>> 8);

endmodule

// File: rtl/fft16_radix4_butterfly.sv
// rtl/fft16_radix4_butterfly.sv - radix-4 butterfly with stage-1 W16 twiddle rotation, 1-cycle latency
// Ports: clk, rst (async active-high, clears calc_out), bus (slave: calc_in,
// rotation -> registered calc_out).
module fft16_radix4_butterfly
  import fft_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  fft16_radix4_butterfly_if.slave   bus
);

  logic [1:0]       pass_n;
  logic             stage2;
  cplx_t            x [4];
  cplx_t            y [4];
  cplx_t            z [4];
  logic [3:0]       tw_p [1:3];
  twiddle_t         tw [1:3];
  cplx_t            prod [1:3];
  logic [BUS_W-1:0] next_out;

  assign pass_n = bus.rotation[1:0];
  assign stage2 = bus.rotation[2];

  // Butterfly; the +-j terms are swaps/negations. All sums wrap at DW bits.
  always_comb begin
    for (int k = 0; k < 4; k++) x[k] = get_slot(bus.calc_in, k);
    y[0].re = x[0].re + x[1].re + x[2].re + x[3].re;
    y[0].im = x[0].im + x[1].im + x[2].im + x[3].im;
    y[1].re = x[0].re + x[1].im - x[2].re - x[3].im;
    y[1].im = x[0].im - x[1].re - x[2].im + x[3].re;
    y[2].re = x[0].re - x[1].re + x[2].re - x[3].re;
    y[2].im = x[0].im - x[1].im + x[2].im - x[3].im;
    y[3].re = x[0].re - x[1].im - x[2].re + x[3].im;
    y[3].im = x[0].im + x[1].re - x[2].im - x[3].re;
  end

  always_comb begin
    for (int k = 1; k < 4; k++) begin
      tw_p[k] = twiddle_idx(pass_n, 2'(k));
      tw[k]   = twiddle(tw_p[k]);
    end
  end

  // Slot 0 always sees p = 0, so only slots 1..3 carry a multiplier.
  for (genvar k = 1; k < 4; k++) begin : g_mult
    cmplx_mult_q8 u_mult (
      .a (y[k]),
      .w (tw[k]),
      .p (prod[k])
    );
  end

  always_comb begin
    next_out = '0;
    z[0] = y[0];
    for (int k = 1; k < 4; k++) begin
      if (stage2 || tw_p[k] == 4'd0) begin
        z[k] = y[k];
      end else if (tw_p[k] == 4'd4) begin
        // (a + jb) * -j = b - ja, exact.
        z[k].re = y[k].im;
        z[k].im = -y[k].re;
      end else begin
        z[k] = prod[k];
      end
    end
    for (int k = 0; k < 4; k++) next_out = put_slot(next_out, k, z[k]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.calc_out <= '0;
    else     bus.calc_out <= next_out;
  end

endmodule

// File: tb/tb_fft16_radix4_butterfly.sv
// tb/tb_fft16_radix4_butterfly.sv - directed-vector bench for fft16_radix4_butterfly
module tb_fft16_radix4_butterfly;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  fft16_radix4_butterfly_if bif ();

  fft16_radix4_butterfly dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  localparam logic [16:0] ONE = 17'h00100;

  function automatic logic [135:0] mk(input logic [16:0] r0, i0, r1, i1, r2, i2, r3, i3);
    return {r3, i3, r2, i2, r1, i1, r0, i0};
  endfunction

  function automatic logic [33:0] slot(input logic [135:0] b, input int m);
    return b[34*m +: 34];
  endfunction

  task automatic drive(input logic [135:0] din, input logic [2:0] rot);
    @(negedge clk);
    bif.calc_in  = din;
    bif.rotation = rot;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [135:0] exp_v;
    tick();
    compared++;
    if (bif.calc_out !== 136'h0) begin
      mismatched++;
      $display("FAIL reset_state: got %h expected 0", bif.calc_out);
    end
    drive(mk(ONE, 0, 0, 0, 0, 0, 0, 0), 3'b000);
    rst = 1'b0;
    tick();
    exp_v = mk(ONE, 0, ONE, 0, ONE, 0, ONE, 0);
    compared++;
    if (bif.calc_out !== exp_v) begin
      mismatched++;
      $display("FAIL reset_release_load: got %h expected %h", bif.calc_out, exp_v);
    end
    #1;
    rst = 1'b1;
    #1;
    compared++;
    if (bif.calc_out !== 136'h0) begin
      mismatched++;
      $display("FAIL reset_async: got %h expected 0", bif.calc_out);
    end
    tick();
    compared++;
    if (bif.calc_out !== 136'h0) begin
      mismatched++;
      $display("FAIL reset_held: got %h expected 0", bif.calc_out);
    end
    drive(mk(ONE, 0, 0, 0, 0, 0, 0, 0), 3'b001);
    rst = 1'b0;
    tick();
    exp_v = mk(ONE, 0, 17'h000ED, 17'h1FF9E, 17'h000B5, 17'h1FF4B, 17'h00062, 17'h1FF13);
    compared++;
    if (bif.calc_out !== exp_v) begin
      mismatched++;
      $display("FAIL reset_release_twiddle: got %h expected %h", bif.calc_out, exp_v);
    end
  endtask

  task automatic test_impulse();
    logic [33:0] exp_s;
    drive(mk(ONE, 0, 0, 0, 0, 0, 0, 0), 3'b000);
    tick();
    exp_s = {ONE, 17'h0};
    for (int m = 0; m < 4; m++) begin
      compared++;
      if (slot(bif.calc_out, m) !== exp_s) begin
        mismatched++;
        $display("FAIL impulse_slot%0d: got %h expected %h", m, slot(bif.calc_out, m), exp_s);
      end
    end
  endtask

  task automatic test_twiddle();
    logic [135:0] exp_v [4];
    exp_v[1] = mk(ONE, 0, 17'h000ED, 17'h1FF9E, 17'h000B5, 17'h1FF4B, 17'h00062, 17'h1FF13);
    exp_v[2] = mk(ONE, 0, 17'h000B5, 17'h1FF4B, 17'h00000, 17'h1FF00, 17'h1FF4B, 17'h1FF4B);
    exp_v[3] = mk(ONE, 0, 17'h00062, 17'h1FF13, 17'h1FF4B, 17'h1FF4B, 17'h1FF13, 17'h00062);
    for (int n = 1; n < 4; n++) begin
      drive(mk(ONE, 0, 0, 0, 0, 0, 0, 0), 3'(n));
      tick();
      for (int m = 0; m < 4; m++) begin
        compared++;
        if (slot(bif.calc_out, m) !== slot(exp_v[n], m)) begin
          mismatched++;
          $display("FAIL twiddle_n%0d_slot%0d: got %h expected %h",
                   n, m, slot(bif.calc_out, m), slot(exp_v[n], m));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [135:0] in_a, in_b, exp_a, exp_b;
    in_a  = mk(ONE, 0, 0, ONE, 0, 0, 0, 0);
    in_b  = mk(0, 0, 0, 0, 0, 0, 0, ONE);
    exp_a = mk(ONE, ONE, 17'h00200, 0, ONE, 17'h1FF00, 0, 0);
    exp_b = mk(ONE, ONE, 17'h001DA, 17'h1FF3C, 0, 17'h1FE96, 0, 0);
    drive(in_a, 3'b100);
    tick();
    compared++;
    if (bif.calc_out !== exp_a) begin
      mismatched++;
      $display("FAIL b2b_stage2_jx1: got %h expected %h", bif.calc_out, exp_a);
    end
    bif.calc_in  = in_a;
    bif.rotation = 3'b001;
    tick();
    compared++;
    if (bif.calc_out !== exp_b) begin
      mismatched++;
      $display("FAIL b2b_stage1_jx1: got %h expected %h", bif.calc_out, exp_b);
    end
    bif.calc_in  = in_b;
    bif.rotation = 3'b100;
    tick();
    compared++;
    if (bif.calc_out !== mk(0, ONE, 17'h1FF00, 0, 0, 17'h1FF00, ONE, 0)) begin
      mismatched++;
      $display("FAIL b2b_stage2_jx3: got %h expected %h", bif.calc_out,
               mk(0, ONE, 17'h1FF00, 0, 0, 17'h1FF00, ONE, 0));
    end
  endtask

  task automatic test_dc_fft();
    logic [135:0] s1 [4];
    logic [135:0] s2_in;
    logic [33:0]  exp_s;
    for (int n = 0; n < 4; n++) begin
      drive(mk(ONE, 0, ONE, 0, ONE, 0, ONE, 0), {1'b0, 2'(n)});
      tick();
      s1[n] = bif.calc_out;
    end
    for (int k1 = 0; k1 < 4; k1++) begin
      s2_in = {slot(s1[3], k1), slot(s1[2], k1), slot(s1[1], k1), slot(s1[0], k1)};
      drive(s2_in, {1'b1, 2'(k1)});
      tick();
      for (int m = 0; m < 4; m++) begin
        exp_s = (k1 == 0 && m == 0) ? {17'h01000, 17'h0} : 34'h0;
        compared++;
        if (slot(bif.calc_out, m) !== exp_s) begin
          mismatched++;
          $display("FAIL dc_bin%0d: got %h expected %h", k1 + 4*m, slot(bif.calc_out, m), exp_s);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [135:0] exp_v;
    drive(mk(17'h0FF00, 0, 17'h0FF00, 0, 17'h0FF00, 0, 17'h0FF00, 0), 3'b100);
    tick();
    exp_v = mk(17'h1FC00, 0, 0, 0, 0, 0, 0, 0);
    compared++;
    if (bif.calc_out !== exp_v) begin
      mismatched++;
      $display("FAIL wrap_stage2: got %h expected %h", bif.calc_out, exp_v);
    end
  endtask

  initial begin
    bif.calc_in  = mk(17'h00555, 17'h00AAA, 17'h00123, 0, 0, 17'h00321, 17'h00777, 0);
    bif.rotation = 3'b011;
    test_reset();
    test_impulse();
    test_twiddle();
    test_back_to_back();
    test_dc_fft();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
